// File: rtl/posit_decode_arbiter.sv
// posit_decode_arbiter
// Two requesters (A and B) share one combinational posit field extractor.
// S1 holds the selected word after sign strip and zero/NaR detection and
// drives it to the extractor. S2 captures the extracted fields together with
// the source tag and the sign/zero/NaR flags, and supports back-pressure.
// Optional feature macro: POSIT_ARB_RR_EN selects round-robin arbitration
// when both requesters are valid. Without it, A has fixed priority.

module posit_decode_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int RS        = 5,
  parameter int ES        = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_a_valid,
  output logic                    o_a_ready,
  input  logic [WORD_SIZE-1:0]    i_a_word,
  input  logic                    i_b_valid,
  output logic                    o_b_ready,
  input  logic [WORD_SIZE-1:0]    i_b_word,
  output logic [WORD_SIZE-1:0]    o_dec_word,
  input  logic                    i_dec_rc,
  input  logic [RS-1:0]           i_dec_regime,
  input  logic [ES-1:0]           i_dec_exp,
  input  logic [WORD_SIZE-ES-1:0] i_dec_mant,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_out_src,
  output logic                    o_out_sign,
  output logic                    o_out_zero,
  output logic                    o_out_nar,
  output logic                    o_out_rc,
  output logic [RS-1:0]           o_out_regime,
  output logic [ES-1:0]           o_out_exp,
  output logic [WORD_SIZE-ES-1:0] o_out_mant
);

  localparam logic [WORD_SIZE-1:0] NAR_WORD = {1'b1, {(WORD_SIZE-1){1'b0}}};

  // S1 stage: word presented to the extractor plus its side-band flags
  logic                 r_s1Valid;
  logic                 r_s1Src;
  logic                 r_s1Sign;
  logic                 r_s1Zero;
  logic                 r_s1Nar;
  logic [WORD_SIZE-1:0] r_decWord;

  // S2 stage: captured result
  logic                    r_outValid;
  logic                    r_outSrc;
  logic                    r_outSign;
  logic                    r_outZero;
  logic                    r_outNar;
  logic                    r_outRc;
  logic [RS-1:0]           r_outRegime;
  logic [ES-1:0]           r_outExp;
  logic [WORD_SIZE-ES-1:0] r_outMant;

  logic                 w_adv2;
  logic                 w_adv1;
  logic                 w_grantB;
  logic                 w_accept;
  logic [WORD_SIZE-1:0] w_selWord;
  logic                 w_selSign;
  logic                 w_selZero;
  logic                 w_selNar;
  logic [WORD_SIZE-1:0] w_selDec;

  assign w_adv2 = ~r_outValid | i_out_ready;
  assign w_adv1 = ~r_s1Valid | w_adv2;

`ifdef POSIT_ARB_RR_EN
  logic r_favourB;

  // Round-robin pointer: after a transfer, favour whoever was not granted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_favourB <= 1'b0;
    end else if (w_accept) begin
      r_favourB <= ~w_grantB;
    end
  end

  assign w_grantB = i_b_valid & (~i_a_valid | r_favourB);
`else
  assign w_grantB = i_b_valid & ~i_a_valid;
`endif

  // Ready only goes to the granted requester, and never while in reset
  assign o_a_ready = ~i_rst & w_adv1 & i_a_valid & ~w_grantB;
  assign o_b_ready = ~i_rst & w_adv1 & i_b_valid &  w_grantB;
  assign w_accept  = o_a_ready | o_b_ready;

  assign w_selWord = w_grantB ? i_b_word : i_a_word;
  assign w_selSign = w_selWord[WORD_SIZE-1];
  assign w_selZero = (w_selWord == '0);
  assign w_selNar  = (w_selWord == NAR_WORD);

  // Magnitude for the extractor; zero and NaR present an all-zero word
  always_comb begin
    w_selDec = w_selWord;
    if (w_selZero || w_selNar) begin
      w_selDec = '0;
    end else if (w_selSign) begin
      w_selDec = '0 - w_selWord;
    end
  end

  // S1 load on accept; the extractor word holds when S1 simply empties
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1Valid <= 1'b0;
      r_s1Src   <= 1'b0;
      r_s1Sign  <= 1'b0;
      r_s1Zero  <= 1'b0;
      r_s1Nar   <= 1'b0;
      r_decWord <= '0;
    end else if (w_adv1) begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Src   <= w_grantB;
        r_s1Sign  <= w_selSign;
        r_s1Zero  <= w_selZero;
        r_s1Nar   <= w_selNar;
        r_decWord <= w_selDec;
      end
    end
  end

  // S2 capture of the extractor fields; special values force fields to zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_outValid  <= 1'b0;
      r_outSrc    <= 1'b0;
      r_outSign   <= 1'b0;
      r_outZero   <= 1'b0;
      r_outNar    <= 1'b0;
      r_outRc     <= 1'b0;
      r_outRegime <= '0;
      r_outExp    <= '0;
      r_outMant   <= '0;
    end else if (w_adv2) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outSrc  <= r_s1Src;
        r_outZero <= r_s1Zero;
        r_outNar  <= r_s1Nar;
        if (r_s1Zero || r_s1Nar) begin
          r_outSign   <= r_s1Nar;
          r_outRc     <= 1'b0;
          r_outRegime <= '0;
          r_outExp    <= '0;
          r_outMant   <= '0;
        end else begin
          r_outSign   <= r_s1Sign;
          r_outRc     <= i_dec_rc;
          r_outRegime <= i_dec_regime;
          r_outExp    <= i_dec_exp;
          r_outMant   <= i_dec_mant;
        end
      end
    end
  end

  assign o_dec_word   = r_decWord;
  assign o_out_valid  = r_outValid;
  assign o_out_src    = r_outSrc;
  assign o_out_sign   = r_outSign;
  assign o_out_zero   = r_outZero;
  assign o_out_nar    = r_outNar;
  assign o_out_rc     = r_outRc;
  assign o_out_regime = r_outRegime;
  assign o_out_exp    = r_outExp;
  assign o_out_mant   = r_outMant;

endmodule

// File: tb/tb_posit_decode_arbiter.sv
// tb_posit_decode_arbiter
// Bench for posit_decode_arbiter. Provides a behavioural posit field
// extractor stub and a transaction-level reference model (a two-entry FIFO
// with one cycle minimum residency plus the arbitration policy).
// Honours POSIT_ARB_RR_EN the same way as the design.

module tb_posit_decode_arbiter;

  localparam int W  = 32;
  localparam int RS = 5;
  localparam int ES = 2;
  localparam int MW = W - ES;
  localparam int FW = 1 + RS + ES + MW;
  localparam logic [W-1:0] NAR = 32'h8000_0000;

`ifdef POSIT_ARB_RR_EN
  localparam bit       RR          = 1'b1;
  localparam logic [5:0] SRC_PATTERN = 6'b101010;
  localparam int       B_READY_CNT = 3;
`else
  localparam bit       RR          = 1'b0;
  localparam logic [5:0] SRC_PATTERN = 6'b000000;
  localparam int       B_READY_CNT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          aValid, bValid, outReady;
  logic [W-1:0]  aWord, bWord;
  logic          aReady, bReady;
  logic [W-1:0]  decWord;
  logic          decRc;
  logic [RS-1:0] decRegime;
  logic [ES-1:0] decExp;
  logic [MW-1:0] decMant;
  logic          outValid, outSrc, outSign, outZero, outNar, outRc;
  logic [RS-1:0] outRegime;
  logic [ES-1:0] outExp;
  logic [MW-1:0] outMant;

  logic [3:0]    outFlags;
  logic [FW-1:0] outFields;
  assign outFlags  = {outSrc, outSign, outZero, outNar};
  assign outFields = {outRc, outRegime, outExp, outMant};

  posit_decode_arbiter #(.WORD_SIZE(W), .RS(RS), .ES(ES)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(aValid), .o_a_ready(aReady), .i_a_word(aWord),
    .i_b_valid(bValid), .o_b_ready(bReady), .i_b_word(bWord),
    .o_dec_word(decWord), .i_dec_rc(decRc), .i_dec_regime(decRegime),
    .i_dec_exp(decExp), .i_dec_mant(decMant),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_out_src(outSrc),
    .o_out_sign(outSign), .o_out_zero(outZero), .o_out_nar(outNar),
    .o_out_rc(outRc), .o_out_regime(outRegime), .o_out_exp(outExp),
    .o_out_mant(outMant)
  );

  // Posit field extractor: regime run after the sign, terminator, exponent, mantissa
  function automatic logic [FW-1:0] extract(input logic [W-1:0] x);
    logic          rc;
    int            k;
    logic          done;
    logic [RS-1:0] rg;
    logic [W-1:0]  rem;
    rc   = x[W-2];
    k    = 0;
    done = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      if (!done && x[i] == rc) k++;
      else done = 1'b1;
    end
    rg  = rc ? RS'(k - 1) : RS'(k);
    rem = (k + 2 >= W) ? '0 : (x << (k + 2));
    return {rc, rg, rem[W-1 -: ES], rem[MW-1:0]};
  endfunction

  assign {decRc, decRegime, decExp, decMant} = extract(decWord);

  typedef struct packed {
    logic          src;
    logic          sign;
    logic          zero;
    logic          nar;
    logic [FW-1:0] fields;
    logic [W-1:0]  dec;
    logic          shown;
  } entry_t;

  entry_t       q[$];
  bit           favourB;
  logic [W-1:0] lastDec;
  bit           expA, expB, expGrantB, fire;
  bit           aPend, bPend;
  logic [W-1:0] aW, bW;
  int           errors = 0;
  int           checks = 0;

  // Expected result for one word, straight from the posit value rules
  function automatic entry_t makeEntry(input logic src, input logic [W-1:0] w);
    entry_t e;
    e.src    = src;
    e.zero   = (w == '0);
    e.nar    = (w == NAR);
    e.sign   = e.nar ? 1'b1 : (e.zero ? 1'b0 : w[W-1]);
    e.dec    = (e.zero || e.nar) ? '0 : (w[W-1] ? ('0 - w) : w);
    e.fields = (e.zero || e.nar) ? '0 : extract(e.dec);
    e.shown  = 1'b0;
    return e;
  endfunction

  function automatic logic [W-1:0] randWord();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return NAR;
      default: return $urandom;
    endcase
  endfunction

  function automatic bit modelOutValid();
    return (q.size() > 0) && q[0].shown;
  endfunction

  // Model prediction for the coming edge given the inputs now applied
  task automatic preEdge();
    bit room;
    fire = modelOutValid() && outReady;
    room = (q.size() - (fire ? 1 : 0)) < 2;
    if (aValid && bValid) expGrantB = RR ? favourB : 1'b0;
    else                  expGrantB = bValid;
    expA = !rst && room && aValid && !expGrantB;
    expB = !rst && room && bValid &&  expGrantB;
  endtask

  // Model state update at the edge
  task automatic postEdge();
    entry_t e;
    if (rst) begin
      q.delete();
      favourB = 1'b0;
      lastDec = '0;
    end else begin
      if (fire) void'(q.pop_front());
      foreach (q[i]) q[i].shown = 1'b1;
      if (expA || expB) begin
        e = makeEntry(expB, expB ? bWord : aWord);
        q.push_back(e);
        lastDec = e.dec;
        favourB = !expB;
        if (expA) aPend = 1'b0;
        if (expB) bPend = 1'b0;
      end
    end
  endtask

  task automatic setup(input logic av, input logic [W-1:0] aw,
                       input logic bv, input logic [W-1:0] bw, input logic ordy);
    aValid   = av;
    aWord    = aw;
    bValid   = bv;
    bWord    = bw;
    outReady = ordy;
    #1;
    preEdge();
  endtask

  task automatic step();
    postEdge();
    @(negedge clk);
  endtask

  task automatic refill();
    if (!aPend) begin aPend = 1'b1; aW = randWord(); end
    if (!bPend) begin bPend = 1'b1; bW = randWord(); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setup(0, '0, 0, '0, 1);
    step();
    step();
    rst = 1'b0;
    setup(0, '0, 0, '0, 1);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
    checks++; if ({aReady, bReady} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {aReady, bReady}); end
    checks++; if (decWord !== '0) begin errors++; $display("[TB] FAIL reset_dec_word: got %h expected 0", decWord); end
    checks++; if ({outFlags, outFields} !== '0) begin errors++; $display("[TB] FAIL reset_fields: got %h expected 0", {outFlags, outFields}); end
    step();
  endtask

  task automatic test_single_a();
    setup(1, 32'h4000_0000, 0, '0, 1);
    checks++; if ({aReady, bReady} !== 2'b10) begin errors++; $display("[TB] FAIL single_a_ready: got %b expected 10", {aReady, bReady}); end
    step();
    setup(0, '0, 0, '0, 1);
    checks++; if (decWord !== 32'h4000_0000) begin errors++; $display("[TB] FAIL single_a_dec_word: got %h expected 40000000", decWord); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL single_a_early_valid: got %b expected 0", outValid); end
    step();
    setup(0, '0, 0, '0, 1);
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL single_a_valid: got %b expected 1", outValid); end
    checks++; if (outFlags !== 4'b0000) begin errors++; $display("[TB] FAIL single_a_flags: got %b expected 0000", outFlags); end
    checks++; if (outFields !== extract(32'h4000_0000)) begin errors++; $display("[TB] FAIL single_a_fields: got %h expected %h", outFields, extract(32'h4000_0000)); end
    step();
  endtask

  task automatic test_single_b();
    setup(0, '0, 1, 32'hC000_0000, 1);
    checks++; if ({aReady, bReady} !== 2'b01) begin errors++; $display("[TB] FAIL single_b_ready: got %b expected 01", {aReady, bReady}); end
    step();
    setup(0, '0, 0, '0, 1);
    checks++; if (decWord !== 32'h4000_0000) begin errors++; $display("[TB] FAIL single_b_dec_word: got %h expected 40000000", decWord); end
    step();
    setup(0, '0, 0, '0, 1);
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL single_b_valid: got %b expected 1", outValid); end
    checks++; if (outFlags !== 4'b1100) begin errors++; $display("[TB] FAIL single_b_flags: got %b expected 1100", outFlags); end
    checks++; if (outFields !== extract(32'h4000_0000)) begin errors++; $display("[TB] FAIL single_b_fields: got %h expected %h", outFields, extract(32'h4000_0000)); end
    step();
  endtask

  task automatic test_zero_nar();
    setup(1, '0, 0, '0, 1);
    checks++; if (aReady !== 1'b1) begin errors++; $display("[TB] FAIL zero_ready: got %b expected 1", aReady); end
    step();
    setup(0, '0, 1, NAR, 1);
    checks++; if (bReady !== 1'b1) begin errors++; $display("[TB] FAIL nar_ready: got %b expected 1", bReady); end
    checks++; if (decWord !== '0) begin errors++; $display("[TB] FAIL zero_dec_word: got %h expected 0", decWord); end
    step();
    setup(0, '0, 0, '0, 1);
    checks++; if ({outValid, outFlags, outFields} !== {1'b1, 4'b0010, {FW{1'b0}}}) begin errors++; $display("[TB] FAIL zero_output: got v=%b flags=%b fields=%h expected v=1 flags=0010 fields=0", outValid, outFlags, outFields); end
    checks++; if (decWord !== '0) begin errors++; $display("[TB] FAIL nar_dec_word: got %h expected 0", decWord); end
    step();
    setup(0, '0, 0, '0, 1);
    checks++; if ({outValid, outFlags, outFields} !== {1'b1, 4'b1101, {FW{1'b0}}}) begin errors++; $display("[TB] FAIL nar_output: got v=%b flags=%b fields=%h expected v=1 flags=1101 fields=0", outValid, outFlags, outFields); end
    step();
    setup(0, '0, 0, '0, 1);
    step();
  endtask

  task automatic test_both_valid();
    logic srcs[$];
    int   bCount = 0;
    aPend = 1'b0;
    bPend = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin
        refill();
        setup(aPend, aW, bPend, bW, 1);
      end else begin
        setup(0, '0, 0, '0, 1);
      end
      checks++; if ({aReady, bReady} !== {expA, expB}) begin errors++; $display("[TB] FAIL both_ready c=%0d: got %b expected %b", c, {aReady, bReady}, {expA, expB}); end
      if (bReady) bCount++;
      if (outValid) srcs.push_back(outSrc);
      step();
    end
    checks++; if (srcs.size() != 6) begin errors++; $display("[TB] FAIL both_out_count: got %0d expected 6", srcs.size()); end
    foreach (srcs[i]) begin
      if (i < 6) begin
        checks++; if (srcs[i] !== SRC_PATTERN[i]) begin errors++; $display("[TB] FAIL both_src[%0d]: got %b expected %b", i, srcs[i], SRC_PATTERN[i]); end
      end
    end
    checks++; if (bCount != B_READY_CNT) begin errors++; $display("[TB] FAIL both_b_ready_count: got %0d expected %0d", bCount, B_READY_CNT); end
    aPend = 1'b0;
    bPend = 1'b0;
  endtask

  task automatic test_stall();
    int acc  = 0;
    int outs = 0;
    for (int c = 0; c < 4; c++) begin
      refill();
      setup(aPend, aW, bPend, bW, 0);
      checks++; if ({aReady, bReady} !== {expA, expB}) begin errors++; $display("[TB] FAIL stall_ready c=%0d: got %b expected %b", c, {aReady, bReady}, {expA, expB}); end
      checks++; if (outValid !== modelOutValid()) begin errors++; $display("[TB] FAIL stall_valid c=%0d: got %b expected %b", c, outValid, modelOutValid()); end
      if (modelOutValid()) begin
        checks++; if ({outFlags, outFields} !== {q[0].src, q[0].sign, q[0].zero, q[0].nar, q[0].fields}) begin errors++; $display("[TB] FAIL stall_hold c=%0d: got %h expected %h", c, {outFlags, outFields}, {q[0].src, q[0].sign, q[0].zero, q[0].nar, q[0].fields}); end
      end
      if (aReady || bReady) acc++;
      step();
    end
    checks++; if (acc != 2) begin errors++; $display("[TB] FAIL stall_accept_count: got %0d expected 2", acc); end
    for (int c = 0; c < 4; c++) begin
      setup(0, '0, 0, '0, 1);
      checks++; if (outValid !== modelOutValid()) begin errors++; $display("[TB] FAIL release_valid c=%0d: got %b expected %b", c, outValid, modelOutValid()); end
      if (modelOutValid()) begin
        outs++;
        checks++; if ({outFlags, outFields} !== {q[0].src, q[0].sign, q[0].zero, q[0].nar, q[0].fields}) begin errors++; $display("[TB] FAIL release_data c=%0d: got %h expected %h", c, {outFlags, outFields}, {q[0].src, q[0].sign, q[0].zero, q[0].nar, q[0].fields}); end
      end
      step();
    end
    checks++; if (outs != 2) begin errors++; $display("[TB] FAIL release_out_count: got %0d expected 2", outs); end
    aPend = 1'b0;
    bPend = 1'b0;
  endtask

  task automatic test_reset_midflight();
    setup(1, 32'h1234_5678, 0, '0, 0);
    step();
    setup(1, 32'h2345_6789, 0, '0, 0);
    step();
    rst = 1'b1;
    setup(1, 32'h0000_0003, 1, 32'h0000_0004, 0);
    checks++; if ({aReady, bReady} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_ready_in_reset: got %b expected 00", {aReady, bReady}); end
    step();
    rst = 1'b0;
    setup(1, 32'h1111_1111, 1, 32'h2222_2222, 1);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", outValid); end
    checks++; if (decWord !== '0) begin errors++; $display("[TB] FAIL midrst_dec_word: got %h expected 0", decWord); end
    checks++; if ({outFlags, outFields} !== '0) begin errors++; $display("[TB] FAIL midrst_fields: got %h expected 0", {outFlags, outFields}); end
    checks++; if ({aReady, bReady} !== 2'b10) begin errors++; $display("[TB] FAIL midrst_first_grant: got %b expected 10", {aReady, bReady}); end
    step();
    for (int c = 0; c < 3; c++) begin
      setup(0, '0, 0, '0, 1);
      step();
    end
  endtask

  task automatic test_random();
    aPend = 1'b0;
    bPend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!aPend && $urandom_range(0, 99) < 60) begin aPend = 1'b1; aW = randWord(); end
      if (!bPend && $urandom_range(0, 99) < 60) begin bPend = 1'b1; bW = randWord(); end
      setup(aPend, aW, bPend, bW, $urandom_range(0, 3) != 0);
      checks++; if ({aReady, bReady} !== {expA, expB}) begin errors++; $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, {aReady, bReady}, {expA, expB}); end
      checks++; if (outValid !== modelOutValid()) begin errors++; $display("[TB] FAIL rand_valid c=%0d: got %b expected %b", c, outValid, modelOutValid()); end
      checks++; if (decWord !== lastDec) begin errors++; $display("[TB] FAIL rand_dec_word c=%0d: got %h expected %h", c, decWord, lastDec); end
      if (modelOutValid()) begin
        checks++; if ({outFlags, outFields} !== {q[0].src, q[0].sign, q[0].zero, q[0].nar, q[0].fields}) begin errors++; $display("[TB] FAIL rand_data c=%0d: got %h expected %h", c, {outFlags, outFields}, {q[0].src, q[0].sign, q[0].zero, q[0].nar, q[0].fields}); end
      end
      step();
    end
    rst = 1'b0;
  endtask

  // Directed scenarios first, then randomized traffic against the model
  initial begin
    rst      = 1'b1;
    aValid   = 1'b0;
    bValid   = 1'b0;
    aWord    = '0;
    bWord    = '0;
    outReady = 1'b1;
    favourB  = 1'b0;
    lastDec  = '0;
    aPend    = 1'b0;
    bPend    = 1'b0;
    aW       = '0;
    bW       = '0;
    @(negedge clk);
    test_reset();
    test_single_a();
    test_single_b();
    test_zero_nar();
    test_both_valid();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
